// File: rtl/psum_postproc.sv
// Partial-sum accumulator with bias, rounded requantization, optional ReLU and saturation,
// feeding a small output FIFO with a valid/ready handshake.
module psum_postproc #(
    parameter int unsigned DATA_BITS     = 16,
    parameter int unsigned INTERNAL_BITS = 32,
    parameter int unsigned GUARD_BITS    = 8,
    parameter int unsigned DEPTH         = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     psum_valid,
    output logic                     psum_ready,
    input  logic [INTERNAL_BITS-1:0] psum_in,
    input  logic                     psum_last,
    input  logic [INTERNAL_BITS-1:0] bias,
    input  logic [4:0]               shift,
    input  logic                     relu_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_BITS-1:0]     out_data,
    output logic [7:0]               term_cnt
);

    localparam int unsigned ACC_BITS = INTERNAL_BITS + GUARD_BITS;
    localparam int unsigned RND_BITS = ACC_BITS + 1;
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;

    localparam logic signed [RND_BITS-1:0] SAT_MAX = (RND_BITS'(1) << (DATA_BITS - 1)) - 1'b1;
    localparam logic signed [RND_BITS-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [ACC_BITS-1:0] acc_q, acc_d;
    logic                       first_q, first_d;
    logic [7:0]                 term_cnt_q, term_cnt_d;
    logic                       done_q, done_d;
    logic [4:0]                 shift_q, shift_d;
    logic                       relu_q, relu_d;

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic [CNT_W-1:0]     occupancy;

    logic signed [ACC_BITS-1:0] psum_ext, bias_ext;
    logic                       accept, push, pop;

    assign psum_ext = {{GUARD_BITS{psum_in[INTERNAL_BITS-1]}}, psum_in};
    assign bias_ext = {{GUARD_BITS{bias[INTERNAL_BITS-1]}}, bias};

    // A pixel sitting in the post stage already owns a FIFO slot.
    assign occupancy  = count_q + {{PTR_W{1'b0}}, done_q};
    assign psum_ready = !clear && (occupancy < CNT_W'(DEPTH));
    assign accept     = psum_valid && psum_ready;
    assign term_cnt   = term_cnt_q;

    always_comb begin
        acc_d      = acc_q;
        first_d    = first_q;
        term_cnt_d = term_cnt_q;
        shift_d    = shift_q;
        relu_d     = relu_q;
        done_d     = accept && psum_last;
        if (clear) begin
            first_d    = 1'b1;
            term_cnt_d = 8'd0;
        end else if (accept) begin
            acc_d = (first_q ? bias_ext : acc_q) + psum_ext;
            if (psum_last) begin
                first_d    = 1'b1;
                term_cnt_d = 8'd0;
                shift_d    = shift;
                relu_d     = relu_en;
            end else begin
                first_d = 1'b0;
                if (term_cnt_q != 8'hff) begin
                    term_cnt_d = term_cnt_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            first_q    <= 1'b1;
            term_cnt_q <= 8'd0;
            done_q     <= 1'b0;
            shift_q    <= 5'd0;
            relu_q     <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            first_q    <= first_d;
            term_cnt_q <= term_cnt_d;
            done_q     <= done_d;
            shift_q    <= shift_d;
            relu_q     <= relu_d;
        end
    end

    // Requantization: one extra bit so the rounding offset cannot overflow.
    logic signed [RND_BITS-1:0] acc_wide, half, rnd_sum, rounded, clamped;
    logic        [DATA_BITS-1:0] result;

    always_comb begin
        acc_wide = {acc_q[ACC_BITS-1], acc_q};
        half     = '0;
        rnd_sum  = acc_wide;
        rounded  = acc_wide;
        if (shift_q != 5'd0) begin
            half    = RND_BITS'(1) << (shift_q - 5'd1);
            rnd_sum = acc_wide + half;
            rounded = rnd_sum >>> shift_q;
        end
        if (relu_q && rounded[RND_BITS-1]) begin
            rounded = '0;
        end
        if (rounded > SAT_MAX) begin
            clamped = SAT_MAX;
        end else if (rounded < SAT_MIN) begin
            clamped = SAT_MIN;
        end else begin
            clamped = rounded;
        end
        result = DATA_BITS'(clamped);
    end

    assign push      = done_q;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= result;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_psum_postproc.sv
// Randomized and directed bench for psum_postproc against an arithmetic pixel-level model.
module tb_psum_postproc;

    localparam int DATA_BITS = 16;
    localparam int DEPTH     = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        psum_valid = 1'b0;
    logic        psum_ready;
    logic [31:0] psum_in = '0;
    logic        psum_last = 1'b0;
    logic [31:0] bias = '0;
    logic [4:0]  shift = '0;
    logic        relu_en = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [7:0]  term_cnt;

    psum_postproc #(
        .DATA_BITS(DATA_BITS),
        .INTERNAL_BITS(32),
        .GUARD_BITS(8),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .psum_valid(psum_valid),
        .psum_ready(psum_ready),
        .psum_in(psum_in),
        .psum_last(psum_last),
        .bias(bias),
        .shift(shift),
        .relu_en(relu_en),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .term_cnt(term_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model state: every finished pixel result not yet popped, in order.
    longint q[$];
    bit     post_pending = 1'b0;
    bit     first_m = 1'b1;
    longint pix_sum = 0;
    int     terms = 0;
    bit     last_ready = 1'b1;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint ref_f(input longint sum, input int s, input bit relu);
        longint d, n, r;
        if (s == 0) begin
            r = sum;
        end else begin
            d = longint'(1) << s;
            n = sum + d / 2;
            r = n / d;
            if ((n % d != 0) && (n < 0)) r = r - 1;
        end
        if (relu && r < 0) r = 0;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    task automatic step(input bit v, input int p, input bit l, input int b, input int s,
                        input bit r, input bit c, input bit ordy);
        bit exp_ready;
        int vis;
        @(negedge clk);
        psum_valid = v;
        psum_in    = p;
        psum_last  = l;
        bias       = b;
        shift      = 5'(s);
        relu_en    = r;
        clear      = c;
        out_ready  = ordy;
        #1;
        exp_ready = !c && (q.size() < DEPTH);
        vis = q.size() - (post_pending ? 1 : 0);
        check("psum_ready", longint'(psum_ready), longint'(exp_ready));
        check("out_valid", longint'(out_valid), longint'(vis > 0));
        if (vis > 0) check("out_data", longint'($signed(out_data)), q[0]);
        check("term_cnt", longint'(term_cnt), longint'(terms));
        if (vis > 0 && ordy) void'(q.pop_front());
        post_pending = 1'b0;
        if (c) begin
            first_m = 1'b1;
            terms   = 0;
        end else if (v && exp_ready) begin
            pix_sum = (first_m ? longint'(b) : pix_sum) + longint'(p);
            pix_sum = (pix_sum <<< 24) >>> 24;
            if (l) begin
                q.push_back(ref_f(pix_sum, s, r));
                post_pending = 1'b1;
                first_m = 1'b1;
                terms   = 0;
            end else begin
                first_m = 1'b0;
                if (terms < 255) terms++;
            end
        end
        last_ready = exp_ready;
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, ordy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        psum_valid = 1'b0;
        clear = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_term_cnt", longint'(term_cnt), 0);
        q.delete();
        post_pending = 1'b0;
        first_m = 1'b1;
        terms = 0;
        last_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_psum_ready", longint'(psum_ready), 1);
    endtask

    function automatic int rand_val();
        case ($urandom % 4)
            0: return $urandom_range(0, 2000) - 1000;
            1: return int'($urandom);
            2: return $urandom_range(0, 4194304) - 2097152;
            default: return $urandom_range(0, 16) - 8;
        endcase
    endfunction

    initial begin
        bit v, l, c, ordy, r;
        int p, b, s;
        do_reset();

        // Basic pixel: 10+100+200-50 = 260, (260+2)>>2 = 65.
        step(1, 100, 0, 10, 0, 0, 0, 1);
        step(1, 200, 0, 0, 0, 0, 0, 1);
        step(1, -50, 1, 0, 2, 1, 0, 1);
        idle(2, 1);
        // ReLU, sign and round-half-up.
        step(1, -300, 1, 0, 0, 1, 0, 1);
        step(1, -300, 1, 0, 0, 0, 0, 1);
        step(1, -5, 1, 0, 1, 0, 0, 1);
        idle(2, 1);
        // Saturation both ways.
        step(1, 1048576, 1, 0, 4, 0, 0, 1);
        step(1, -1048576, 1, 0, 4, 0, 0, 1);
        idle(2, 1);
        // Backpressure: four results fill the FIFO, fifth is held off.
        for (int i = 1; i <= 4; i++) step(1, i, 1, 0, 0, 0, 0, 0);
        step(1, 5, 1, 0, 0, 0, 0, 0);
        step(1, 5, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 6 + i, 1, 0, 0, 0, 0, 1);
        idle(6, 1);
        // Clear mid-pixel, with a valid psum on the clear cycle.
        step(1, 50, 0, 0, 0, 0, 0, 1);
        step(1, 7, 1, 0, 0, 0, 1, 1);
        step(1, 7, 1, 0, 0, 0, 0, 1);
        idle(2, 1);
        // term_cnt saturation.
        for (int i = 0; i < 260; i++) step(1, 1, 0, 0, 0, 0, 0, 1);
        step(1, 1, 1, 0, 0, 0, 0, 1);
        idle(2, 1);
        // Reset with two entries queued and a third in the post stage.
        step(1, 11, 1, 0, 0, 0, 0, 0);
        step(1, 22, 1, 0, 0, 0, 0, 0);
        step(1, 33, 1, 0, 0, 0, 0, 0);
        do_reset();
        idle(3, 1);

        // Randomized traffic with alternating backpressure phases.
        v = 0; p = 0; l = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!(v && !last_ready)) begin
                v = ($urandom % 4) != 0;
                p = rand_val();
                l = ($urandom % 3) == 0;
            end
            b = rand_val();
            s = (($urandom % 4) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 6);
            r = $urandom % 2;
            c = ($urandom % 16) == 0;
            ordy = ((i / 64) % 2 == 1) ? (($urandom % 4) != 0) : (($urandom % 4) == 0);
            step(v, p, l, b, s, r, c, ordy);
        end
        idle(10, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
